// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder built from four full-adder cells, with the
// {carry, sum} result registered once per clock.

module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum_c,
    output logic o_cout_c
);

    logic w_axb;

    assign w_axb    = i_a ^ i_b;
    assign o_sum_c  = w_axb ^ i_cin;
    assign o_cout_c = (i_a & i_b) | (i_cin & w_axb);

endmodule

module rca_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Sum,
    output logic       Cout
);

    localparam int unsigned W = 4;

    logic [W:0]   w_c;
    logic [W-1:0] w_s;
    logic [W-1:0] r_sum;
    logic         r_cout;

    // Carry chain enters with no carry-in; w_c[W] is the carry out of bit 3.
    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_stage
        fa_cell u_fa (
            .i_a      (A[i]),
            .i_b      (B[i]),
            .i_cin    (w_c[i]),
            .o_sum_c  (w_s[i]),
            .o_cout_c (w_c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= W'(0);
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[W];
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: directed cases, reset behaviour,
// exhaustive sweep and random vectors against an arithmetic reference.

module tb_rca_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sum;
    logic       Cout;

    int n_vec;
    int n_err;

    rca_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got n_vec=%0d required completion", n_vec);
        $fatal(1, "watchdog");
    end

    // Reference: 5-bit unsigned sum of the two operands.
    function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return 5'(s);
    endfunction

    // Present operands mid-cycle, then sample just after the next rising edge.
    task automatic tick(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        A = 4'h7;
        B = 4'h6;
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({Cout, Sum} !== 5'b0_0000) begin
            n_err++;
            $display("FAIL reset_async: got %b required 00000", {Cout, Sum});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({Cout, Sum} !== 5'b0_0000) begin
            n_err++;
            $display("FAIL reset_hold: got %b required 00000", {Cout, Sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        A = 4'h9;
        B = 4'h8;
        @(posedge clk);
        #1;
        n_vec++;
        if ({Cout, Sum} !== 5'b1_0001) begin
            n_err++;
            $display("FAIL reset_release_first_edge: got %b required 10001", {Cout, Sum});
        end
    endtask

    task automatic test_directed;
        logic [3:0] ta [5];
        logic [3:0] tb [5];
        logic [4:0] te [5];
        ta = '{4'b0001, 4'b0100, 4'b1111, 4'b1010, 4'b1111};
        tb = '{4'b0010, 4'b0011, 4'b0001, 4'b0101, 4'b1111};
        te = '{5'b0_0011, 5'b0_0111, 5'b1_0000, 5'b0_1111, 5'b1_1110};
        for (int i = 0; i < 5; i++) begin
            tick(ta[i], tb[i]);
            n_vec++;
            if ({Cout, Sum} !== te[i]) begin
                n_err++;
                $display("FAIL directed_%0d: A=%b B=%b got %b required %b",
                         i, ta[i], tb[i], {Cout, Sum}, te[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        tick(4'b1111, 4'b0001);
        n_vec++;
        if ({Cout, Sum} !== 5'b1_0000) begin
            n_err++;
            $display("FAIL midreset_pre: got %b required 10000", {Cout, Sum});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({Cout, Sum} !== 5'b0_0000) begin
            n_err++;
            $display("FAIL midreset_immediate: got %b required 00000", {Cout, Sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({Cout, Sum} !== 5'b1_0000) begin
            n_err++;
            $display("FAIL midreset_release: got %b required 10000", {Cout, Sum});
        end
    endtask

    task automatic test_sweep;
        logic [4:0] exp_v;
        logic [3:0] a;
        logic [3:0] b;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            exp_v = ref_sum(a, b);
            tick(a, b);
            n_vec++;
            if ({Cout, Sum} !== exp_v) begin
                n_err++;
                $display("FAIL sweep: A=%h B=%h got %b required %b", a, b, {Cout, Sum}, exp_v);
            end
            // Outputs must ignore operand changes between edges.
            A = 4'($urandom);
            B = 4'($urandom);
            #2;
            n_vec++;
            if ({Cout, Sum} !== exp_v) begin
                n_err++;
                $display("FAIL sweep_hold: A=%h B=%h got %b required %b", a, b, {Cout, Sum}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_q [$];
        logic [4:0] exp_v;
        logic [3:0] a;
        logic [3:0] b;
        for (int i = 0; i < 200; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            exp_q.push_back(ref_sum(a, b));
            tick(a, b);
            exp_v = exp_q.pop_front();
            n_vec++;
            if ({Cout, Sum} !== exp_v) begin
                n_err++;
                $display("FAIL random: A=%h B=%h got %b required %b", a, b, {Cout, Sum}, exp_v);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        A = 4'h0;
        B = 4'h0;
        test_reset;
        test_directed;
        test_reset_mid;
        test_sweep;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rca_4bit.md
RCA_4BIT -- requirements
Module: rca_4bit

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits and carry-in is fixed at 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  4  unsigned operand A.
REQ-005 B  input  4  unsigned operand B.
REQ-006 Sum  output  4  registered sum bits, (A+B) mod 16.
REQ-007 Cout  output  1  registered carry out of bit 3.
REQ-008 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.

Function
REQ-009 The adder datapath SHALL be a ripple chain of four full-adder stages: stage i takes A[i], B[i], c[i] and produces s[i], c[i+1].
REQ-010 c[0] SHALL be constant 0; c[4] SHALL be the carry out.
REQ-011 Each full-adder stage SHALL compute s = a XOR b XOR cin and cout = (a AND b) OR (cin AND (a XOR b)).
REQ-012 The full-adder stage SHALL be a separate reusable cell instantiated four times; no behavioural "+" in the datapath.
REQ-013 On each rising clk with rst_n high, the module SHALL register Sum <= s[3:0] and Cout <= c[4] from the A/B present at that edge.
REQ-014 Latency SHALL be exactly one clock: outputs reflect operands sampled at the most recent rising edge.
REQ-015 Sum and Cout SHALL hold their values between edges regardless of A/B changes.
REQ-016 {Cout, Sum} SHALL equal the 5-bit unsigned sum A+B, range 0..30.
REQ-017 Overflow (A+B >= 16) SHALL wrap Sum modulo 16 and set Cout=1; no other flag.
REQ-018 Operand bits that are X/Z are unspecified; the bench SHALL drive only known values.
REQ-019 There SHALL be no handshake and no enable; a new result is registered every cycle.

Reset
REQ-020 While rst_n is low, Sum SHALL be 4'b0000 and Cout SHALL be 0, asserted immediately, without waiting for clk.
REQ-021 When rst_n is deasserted, the first rising clk SHALL load the result for the current A/B.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; no partial value SHALL appear on the outputs.

Verification
REQ-023 A=0001, B=0010, one clk -> Sum=0011, Cout=0.
REQ-024 A=0100, B=0011, one clk -> Sum=0111, Cout=0.
REQ-025 A=1111, B=0001, one clk -> Sum=0000, Cout=1 (full carry ripple).
REQ-026 A=1010, B=0101, one clk -> Sum=1111, Cout=0. Then A=1111, B=1111 -> Sum=1110, Cout=1.
REQ-027 Apply A=1111, B=0001, clock once, then drop rst_n between edges -> Sum=0000 and Cout=0 immediately. Release rst_n and clock -> Sum=0000, Cout=1.
REQ-028 Exhaustive sweep of all 256 A/B pairs, one per clk, checking {Cout,Sum} == A+B one cycle later -> zero mismatches; Sum/Cout SHALL be stable between edges.
